// File: rtl/cmd_frame_rx_pkg.sv
// cmd_frame_rx_pkg: shared constants and FSM state type for the command frame receiver
package cmd_frame_rx_pkg;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int SPEED_LSB = 4;
  localparam int DIR_LSB = 0;
  localparam int MODE_LSB = 0;
  localparam logic [1:0] DEF_MODE = 2'd0;
  typedef enum logic [1:0] {HUNT, GOT_B1_WAIT, GOT_B2_WAIT, CHK_WAIT} state_t;
endpackage

// File: rtl/cmd_frame_rx_err_window.sv
// rx_err_window: counts frames per window and latches the saturated bad-frame count
module rx_err_window #(
  parameter int win_frames = 16,
  parameter int cmd_l = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_done,
  input  logic             frame_bad,
  output logic [cmd_l-1:0] err_rate
);
  localparam int FW = $clog2(win_frames + 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(win_frames - 1);
  logic [FW-1:0] frame_cnt;
  logic [cmd_l-1:0] err_cnt, err_next;
  always_comb err_next = (frame_bad && err_cnt != '1) ? err_cnt + 1'b1 : err_cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= '0;
      err_cnt <= '0;
      err_rate <= '0;
    end else if (frame_done) begin
      if (frame_cnt == FRAME_LAST) begin
        err_rate <= err_next;
        frame_cnt <= '0;
        err_cnt <= '0;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
        err_cnt <= err_next;
      end
    end
  end
endmodule

// File: rtl/cmd_frame_rx.sv
// cmd_frame_rx: assembles and checksums 4-byte command frames, with gap abort and link timeout
module cmd_frame_rx
  import cmd_frame_rx_pkg::*;
#(
  parameter int def_speed_cmd = 5,
  parameter int def_dir_cmd = 8,
  parameter int cmd_l = 4,
  parameter int win_frames = 16,
  parameter int byte_gap_max = 64,
  parameter int timeout_cyc = 100000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic [cmd_l-1:0] speed_cmd_o,
  output logic [cmd_l-1:0] dir_cmd_o,
  output logic [1:0]       mode_o,
  output logic [cmd_l-1:0] err_rate_o,
  output logic             frame_ok,
  output logic             frame_err,
  output logic             link_lost
);
  localparam int GW = $clog2(byte_gap_max + 1);
  localparam int IW = $clog2(timeout_cyc + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(byte_gap_max - 1);
  localparam logic [IW-1:0] IDLE_MAX = IW'(timeout_cyc);
  localparam logic [IW-1:0] IDLE_LAST = IW'(timeout_cyc - 1);
  localparam logic [cmd_l-1:0] DEF_SPEED = cmd_l'(def_speed_cmd);
  localparam logic [cmd_l-1:0] DEF_DIR = cmd_l'(def_dir_cmd);
  state_t state, state_n;
  logic [7:0] b1, b2;
  logic [GW-1:0] gap_cnt;
  logic [IW-1:0] idle_cnt;
  logic good, bad, gap_abort;
  always_comb begin
    state_n = state;
    good = 1'b0;
    bad = 1'b0;
    gap_abort = state != HUNT && !rx_valid && gap_cnt == GAP_LAST;
    case (state)
      HUNT:        if (rx_valid && rx_data == SYNC_BYTE) state_n = GOT_B1_WAIT;
      GOT_B1_WAIT: if (rx_valid) state_n = GOT_B2_WAIT;
      GOT_B2_WAIT: if (rx_valid) state_n = CHK_WAIT;
      CHK_WAIT: if (rx_valid) begin
        state_n = HUNT;
        good = rx_data == (b1 ^ b2);
        bad = !good;
      end
      default: state_n = HUNT;
    endcase
    if (gap_abort) begin
      state_n = HUNT;
      bad = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= HUNT;
      b1 <= '0;
      b2 <= '0;
      gap_cnt <= '0;
      idle_cnt <= '0;
      frame_ok <= 1'b0;
      frame_err <= 1'b0;
      link_lost <= 1'b0;
      speed_cmd_o <= DEF_SPEED;
      dir_cmd_o <= DEF_DIR;
      mode_o <= DEF_MODE;
    end else begin
      state <= state_n;
      gap_cnt <= (state == HUNT || rx_valid) ? '0 : gap_cnt + 1'b1;
      if (rx_valid && state == GOT_B1_WAIT) b1 <= rx_data;
      if (rx_valid && state == GOT_B2_WAIT) b2 <= rx_data;
      frame_ok <= good;
      frame_err <= bad;
      idle_cnt <= good ? '0 : (idle_cnt == IDLE_MAX ? idle_cnt : idle_cnt + 1'b1);
      // a good frame takes priority over a timeout expiring in the same cycle
      if (good) begin
        speed_cmd_o <= b1[SPEED_LSB +: cmd_l];
        dir_cmd_o <= b1[DIR_LSB +: cmd_l];
        mode_o <= b2[MODE_LSB +: 2];
        link_lost <= 1'b0;
      end else if (idle_cnt == IDLE_LAST) begin
        speed_cmd_o <= DEF_SPEED;
        dir_cmd_o <= DEF_DIR;
        mode_o <= DEF_MODE;
        link_lost <= 1'b1;
      end
    end
  end
  rx_err_window #(.win_frames(win_frames), .cmd_l(cmd_l)) u_win (
    .clk(clk),
    .rst(rst),
    .frame_done(good | bad),
    .frame_bad(bad),
    .err_rate(err_rate_o)
  );
endmodule

// File: doc/cmd_frame_rx.md
Name: cmd_frame_rx

Overview:
- Receive-side command decoder that sits directly upstream of the dynamic-TMR controller.
- Accepts a byte stream from the link PHY/UART and assembles 4-byte command frames.
- Validates each frame by checksum, then produces registered speed_cmd, dir_cmd and mode.
- Produces a windowed err_rate and a link-loss indication; on loss, outputs fall back to safe defaults.

Parameters:
- def_speed_cmd, 5, speed output after reset or link loss.
- def_dir_cmd, 8, direction output after reset or link loss.
- cmd_l, 4, command width; legal range 1..4 (nibble-packed in frame, low cmd_l bits used).
- win_frames, 16, frames (good + bad) per err_rate measurement window.
- byte_gap_max, 64, max idle cycles between bytes inside a frame.
- timeout_cyc, 100000, cycles without a good frame before link_lost.

Ports:
- clk  input  1  system clock; single clock domain.
- rst  input  1  reset, synchronous, active-high.
- rx_data  input  8  received byte.
- rx_valid  input  1  rx_data valid this cycle; no backpressure, every strobe is consumed.
- speed_cmd_o  output  cmd_l  decoded speed command.
- dir_cmd_o  output  cmd_l  decoded direction command.
- mode_o  output  2  decoded operation mode.
- err_rate_o  output  cmd_l  bad frames counted in the last completed window, saturated.
- frame_ok  output  1  one-cycle pulse when a good frame is applied.
- frame_err  output  1  one-cycle pulse when a frame is rejected.
- link_lost  output  1  high while the timeout is expired.

Behaviour:
- Frame format:
  - B0 = SYNC 0xA5.
  - B1 = {speed[3:0], dir[3:0]}.
  - B2 = {6'b reserved, mode[1:0]}.
  - B3 = B1 ^ B2.
- Reset values:
  - speed_cmd_o = def_speed_cmd, dir_cmd_o = def_dir_cmd, mode_o = 0, err_rate_o = 0.
  - frame_ok = 0, frame_err = 0, link_lost = 0.
  - All counters = 0; FSM in HUNT.
- FSM states and transitions:
  - HUNT: a byte equal to SYNC moves to GOT_B1_WAIT. Any other byte is discarded and not counted as an error.
  - GOT_B1_WAIT: the next byte is latched as B1; move to GOT_B2_WAIT.
  - GOT_B2_WAIT: the next byte is latched as B2; move to CHK_WAIT.
  - CHK_WAIT: the next byte is compared against B1^B2; always return to HUNT.
    - Match: outputs load from B1/B2 (low cmd_l bits of each nibble) and frame_ok pulses, both registered in the cycle after the checksum byte is sampled.
    - Mismatch: frame_err pulses with the same timing; outputs are unchanged.
  - Reserved bits of B2 are ignored.
- Inter-byte gap:
  - Applies in the non-HUNT states.
  - A gap counter increments on each cycle without rx_valid and clears on rx_valid.
  - When it reaches byte_gap_max: return to HUNT, pulse frame_err, count as a bad frame.
  - A SYNC byte received mid-frame is treated as data, not as a resync.
- err_rate window:
  - frame_cnt counts completed frames (good, bad or gap-aborted); err_cnt counts bad ones.
  - On the frame that makes frame_cnt == win_frames:
    - err_rate_o <= min(err_cnt including this frame, 2^cmd_l-1).
    - Both counters clear.
  - err_cnt saturates internally.
  - Between windows err_rate_o holds.
- Link timeout:
  - The idle counter increments every cycle, clears on frame_ok, and saturates at timeout_cyc.
  - On reaching timeout_cyc:
    - link_lost <= 1.
    - speed_cmd_o, dir_cmd_o and mode_o revert to defaults in the same cycle.
  - The next frame_ok clears link_lost and applies that frame's values.
- Simultaneous events:
  - A good frame completing in the same cycle the timeout would expire: the good frame wins and link_lost stays 0.
  - A gap abort and a new rx_valid cannot coincide, because rx_valid clears the gap counter first.
- Reset mid-frame: the partial frame is dropped and not counted; all outputs return to reset values on the next edge.

Decomposition:
- Shared package:
  - Constant SYNC_BYTE = 8'hA5.
  - FSM state enum (HUNT, GOT_B1_WAIT, GOT_B2_WAIT, CHK_WAIT).
  - Nibble field offsets for B1/B2.
  - Default mode constant.
- Sub-module rx_err_window:
  - Inputs: frame_done and frame_bad strobes.
  - Holds the frame/error counters and the saturating err_rate register.
  - Parameterised by win_frames and cmd_l.

Test Plan:
- Good frame: bytes A5,78,02,7A on consecutive cycles → one cycle after 7A: speed_cmd_o=7, dir_cmd_o=8, mode_o=2, frame_ok=1 for 1 cycle.
- Bad checksum: A5,78,02,7B → frame_err pulse; outputs keep their previous values; err_cnt=1.
- Noise and gap:
  - Bytes 00,FF before A5 → ignored, no error.
  - A5,78 then a 64-cycle gap → frame_err, FSM returns to HUNT.
- Window: 16 frames with 3 bad → at the 16th frame err_rate_o=3. A subsequent window with 16 bad → err_rate_o=15 (saturated).
- Timeout:
  - With timeout_cyc=50, apply a good frame then silence → at cycle 50 link_lost=1, speed=5, dir=8, mode=0.
  - A next good frame → link_lost=0 and the new values apply.
- Reset: assert rst after A5,78 → defaults restored. A following complete frame decodes correctly, with no stale B1.
